register_file_sb: RTL and testbench
===================================

# register_file_sb

Sixteen-entry, 16-bit register file with a per-register pending-write scoreboard, placed between decode and writeback of the 16-bit pipeline. Writeback drives the write port, which is decoded to a one-hot 16-bit wordline, one bit per register. Decode reads two source operands and the busy status of each. Decode also marks the destination of each issued instruction as pending until its writeback retires.

## Interface
- No parameters.
- clk  in  1  rising-edge clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- SrcReg1  in  4  read port 1 register id
- SrcReg2  in  4  read port 2 register id
- SrcData1  out  16  combinational read data, port 1
- SrcData2  out  16  combinational read data, port 2
- Busy1  out  1  SrcReg1 has a pending write
- Busy2  out  1  SrcReg2 has a pending write
- WriteReg  in  1  writeback enable
- DstReg  in  4  writeback register id
- DstData  in  16  writeback data
- IssueReg  in  1  decode issues an instruction that writes a register
- IssueId  in  4  destination id of the issuing instruction
- Stall  out  1  Busy1 | Busy2, for the hazard unit

## Operation
- Storage is 16 x 16-bit flops, R0..R15.
- R0 is hardwired to zero:
  - reads of R0 return 16'h0000 and Busy for R0 is 0
  - writes and issues to R0 are ignored
- Write decode: wordline bit i = WriteReg & (DstReg == i), one-hot or all-zero. Register i loads DstData at posedge when its wordline bit is 1 and i != 0.
- Reads are combinational: SrcDataN = R[SrcRegN], subject to the bypass rule in Configuration.
- Scoreboard: busy[15:0], with busy[0] tied to 0. Next-state per register i != 0:
  - set when IssueReg & IssueId == i
  - else clear when WriteReg & DstReg == i
  - else hold
- Issue and writeback to the same register in the same cycle: busy stays 1, because the newer producer wins. The register data is still written.
- Writeback to a register that is not busy: data is written, busy stays 0. Legal, no error.
- Repeated issue to a busy register: busy stays 1. There is no counting; the single bit tracks the youngest producer only.
- BusyN = busy[SrcRegN], the pre-update value, subject to the bypass rule.
- Reset: every R[i] = 16'h0000 and busy = 16'h0000. Outputs after reset: SrcData1/2 = 0, Busy1/2 = 0, Stall = 0.
- Reset mid-operation discards all pending-write state. A writeback arriving in the same cycle as rst is dropped.

## Timing
- Read latency: 0 cycles, combinational from SrcReg to SrcData and Busy.
- Write latency: 1 cycle. Data is visible through the array on the cycle after WriteReg is sampled, or in the same cycle when bypass is enabled.
- Scoreboard latency: an issue at edge k makes busy visible after edge k.
- A writeback at edge k clears busy after edge k, or in the same cycle when bypass is enabled.
- No handshake: WriteReg and IssueReg are single-cycle strobes, one per cycle maximum each.

## Configuration
- RF_BYPASS_EN defined: write-to-read forwarding is enabled.
  - When WriteReg & DstReg == SrcRegN & DstReg != 0, SrcDataN = DstData combinationally and BusyN = 0 in that same cycle.
  - This holds even if IssueId also equals DstReg in that cycle, because decode's own sources see pre-issue state.
- RF_BYPASS_EN undefined: reads return the pre-write array value and the pre-update busy bit.
  - A same-cycle write is visible only on the following cycle.
  - Decode stalls one extra cycle on a RAW hazard.

## Test plan
- Reset: assert rst for 2 cycles after writing R5 = 16'hBEEF → every SrcData reads 0, Busy1/2 = 0, Stall = 0.
- Write/read all: write R1..R15 with 16'h1111 * i, then read every pair → exact values; R0 reads 0 after an attempted write of 16'hFFFF.
- Scoreboard: issue R3 → Busy1 = 1 and Stall = 1 with SrcReg1 = 3. Write back R3 = 16'h00A5 two cycles later → busy clears and data reads 16'h00A5.
- Same-cycle issue and writeback to R7 → R7 gets the data and busy[7] stays 1. A following writeback to R7 clears it.
- Bypass: with SrcReg2 = DstReg = 9, WriteReg = 1, DstData = 16'h1234 and R9 busy:
  - with RF_BYPASS_EN: SrcData2 = 16'h1234 and Busy2 = 0 in the same cycle
  - without it: old R9 value and Busy2 = 1, then 16'h1234 and Busy2 = 0 the next cycle
- Mid-operation reset: issue R4, assert rst, deassert → Busy for R4 = 0 and R4 = 0.

Source files
------------

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - 16x16 register file with pending-write scoreboard (optional forwarding: RF_BYPASS_EN)
module register_file_sb (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  SrcReg1,
  input  logic [3:0]  SrcReg2,
  output logic [15:0] SrcData1,
  output logic [15:0] SrcData2,
  output logic        Busy1,
  output logic        Busy2,
  input  logic        WriteReg,
  input  logic [3:0]  DstReg,
  input  logic [15:0] DstData,
  input  logic        IssueReg,
  input  logic [3:0]  IssueId,
  output logic        Stall
);

  logic [15:0] r_regs [16];
  logic [15:0] r_busy;

  logic [15:0] w_wordline;
  logic [15:0] w_issue_line;
  logic [15:0] w_arr1;
  logic [15:0] w_arr2;
  logic        w_sb1;
  logic        w_sb2;

  // One-hot write and issue decode; bit 0 is masked so R0 can never be written or marked busy
  always_comb begin
    w_wordline   = 16'h0000;
    w_issue_line = 16'h0000;
    if (WriteReg) w_wordline   = (16'h0001 << DstReg) & 16'hFFFE;
    if (IssueReg) w_issue_line = (16'h0001 << IssueId) & 16'hFFFE;
  end

  // Register array: each register loads on its own wordline bit; reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= 16'h0000;
    end else begin
      for (int i = 1; i < 16; i++) begin
        if (w_wordline[i]) r_regs[i] <= DstData;
      end
    end
  end

  // Scoreboard: issue sets (youngest producer wins over a same-cycle retire), writeback clears
  always_ff @(posedge clk) begin
    if (rst) r_busy <= 16'h0000;
    else     r_busy <= ((r_busy & ~w_wordline) | w_issue_line) & 16'hFFFE;
  end

  // Pre-write array and scoreboard view for both read ports; R0 always reads zero and never busy
  always_comb begin
    w_arr1 = (SrcReg1 == 4'd0) ? 16'h0000 : r_regs[SrcReg1];
    w_arr2 = (SrcReg2 == 4'd0) ? 16'h0000 : r_regs[SrcReg2];
    w_sb1  = r_busy[SrcReg1];
    w_sb2  = r_busy[SrcReg2];
  end

`ifdef RF_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;

  // Forward the in-flight writeback to a matching source; the retiring write makes it ready now,
  // even if decode re-issues the same destination this cycle
  always_comb begin
    w_fwd1   = w_wordline[SrcReg1];
    w_fwd2   = w_wordline[SrcReg2];
    SrcData1 = w_fwd1 ? DstData : w_arr1;
    SrcData2 = w_fwd2 ? DstData : w_arr2;
    Busy1    = w_fwd1 ? 1'b0 : w_sb1;
    Busy2    = w_fwd2 ? 1'b0 : w_sb2;
    Stall    = Busy1 | Busy2;
  end
`else
  // Without forwarding a same-cycle write shows up only after the edge
  always_comb begin
    SrcData1 = w_arr1;
    SrcData2 = w_arr2;
    Busy1    = w_sb1;
    Busy2    = w_sb2;
    Stall    = Busy1 | Busy2;
  end
`endif

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - scoreboard testbench for register_file_sb
module tb_register_file_sb;

  logic        clk;
  logic        rst;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic [15:0] SrcData1;
  logic [15:0] SrcData2;
  logic        Busy1;
  logic        Busy2;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic        IssueReg;
  logic [3:0]  IssueId;
  logic        Stall;

  register_file_sb dut (
    .clk      (clk),
    .rst      (rst),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .SrcData1 (SrcData1),
    .SrcData2 (SrcData2),
    .Busy1    (Busy1),
    .Busy2    (Busy2),
    .WriteReg (WriteReg),
    .DstReg   (DstReg),
    .DstData  (DstData),
    .IssueReg (IssueReg),
    .IssueId  (IssueId),
    .Stall    (Stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        b1;
    logic        b2;
    logic        st;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: register contents and the set of registers awaiting writeback
  logic [15:0] m_reg  [16];
  bit          m_busy [16];

  task automatic check(input string tag, input string field, input logic [15:0] got, input logic [15:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s %s: got %h, expected %h", tag, field, got, want);
    end
  endtask

  // Monitor: compare every presented output set against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check(mon_e.tag, "SrcData1", SrcData1, mon_e.d1);
      check(mon_e.tag, "SrcData2", SrcData2, mon_e.d2);
      check(mon_e.tag, "Busy1", {15'h0, Busy1}, {15'h0, mon_e.b1});
      check(mon_e.tag, "Busy2", {15'h0, Busy2}, {15'h0, mon_e.b2});
      check(mon_e.tag, "Stall", {15'h0, Stall}, {15'h0, mon_e.st});
    end
  end

  function automatic void model_read(input logic [3:0] s, input logic we, input logic [3:0] dst,
                                     input logic [15:0] data, output logic [15:0] d, output logic b);
    d = (s == 4'd0) ? 16'h0000 : m_reg[s];
    b = (s == 4'd0) ? 1'b0 : m_busy[s];
`ifdef RF_BYPASS_EN
    if (we && dst == s && dst != 4'd0) begin
      d = data;
      b = 1'b0;
    end
`else
    if (we && dst == s && data == 16'h0 && d == 16'h0) b = b;
`endif
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, then advance the model at the edge
  task automatic step(input string tag, input bit chk, input logic r,
                      input logic [3:0] s1, input logic [3:0] s2,
                      input logic we, input logic [3:0] dst, input logic [15:0] data,
                      input logic iss, input logic [3:0] id);
    exp_t e;
    rst = r; SrcReg1 = s1; SrcReg2 = s2;
    WriteReg = we; DstReg = dst; DstData = data;
    IssueReg = iss; IssueId = id;
    if (chk) begin
      e.tag = tag;
      model_read(s1, we, dst, data, e.d1, e.b1);
      model_read(s2, we, dst, data, e.d2, e.b2);
      e.st = e.b1 | e.b2;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 16; i++) begin
        m_reg[i]  = 16'h0000;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we && dst != 4'd0) begin
        m_reg[dst]  = data;
        m_busy[dst] = 1'b0;
      end
      if (iss && id != 4'd0) m_busy[id] = 1'b1;
    end
    #1;
  endtask

  task automatic rd(input string tag, input logic [3:0] s1, input logic [3:0] s2);
    step(tag, 1'b1, 1'b0, s1, s2, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_reg[i]  = 16'h0000;
      m_busy[i] = 1'b0;
    end
    rst = 1'b1; SrcReg1 = 4'd0; SrcReg2 = 4'd0; WriteReg = 1'b0; DstReg = 4'd0;
    DstData = 16'h0; IssueReg = 1'b0; IssueId = 4'd0;
    @(posedge clk); #1;
    step("init_rst", 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    step("init_rst", 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);

    // Reset state
    rd("reset_state", 4'd0, 4'd0);
    rd("reset_state", 4'd5, 4'd15);

    // Reset after a write wipes the array
    step("wr_r5", 1'b1, 1'b0, 4'd5, 4'd1, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0);
    rd("r5_beef", 4'd5, 4'd5);
    step("rst_hold", 1'b1, 1'b1, 4'd5, 4'd5, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    step("rst_hold", 1'b1, 1'b1, 4'd5, 4'd5, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    rd("after_rst", 4'd5, 4'd1);

    // Write every register, then try to write R0
    for (int i = 1; i < 16; i++)
      step("wr_all", 1'b1, 1'b0, 4'(i), 4'(16 - i), 1'b1, 4'(i), 16'(16'h1111 * i), 1'b0, 4'd0);
    step("wr_r0", 1'b1, 1'b0, 4'd0, 4'd1, 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) rd("rd_all", 4'(i), 4'(15 - i));

    // Scoreboard set by issue, cleared by writeback two cycles later
    step("iss_r3", 1'b1, 1'b0, 4'd3, 4'd0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3);
    rd("r3_busy", 4'd3, 4'd0);
    step("wb_r3", 1'b1, 1'b0, 4'd3, 4'd2, 1'b1, 4'd3, 16'h00A5, 1'b0, 4'd0);
    rd("r3_done", 4'd3, 4'd3);

    // Same-cycle issue and writeback: newer producer keeps the register busy
    step("iss_wb_r7", 1'b1, 1'b0, 4'd7, 4'd1, 1'b1, 4'd7, 16'h7777, 1'b1, 4'd7);
    rd("r7_still_busy", 4'd7, 4'd7);
    step("wb_r7", 1'b1, 1'b0, 4'd1, 4'd7, 1'b1, 4'd7, 16'hC0DE, 1'b0, 4'd0);
    rd("r7_done", 4'd7, 4'd0);

    // Writeback to a busy R9 while port 2 reads it
    step("iss_r9", 1'b1, 1'b0, 4'd9, 4'd9, 1'b0, 4'd0, 16'h0, 1'b1, 4'd9);
    step("bypass_r9", 1'b1, 1'b0, 4'd1, 4'd9, 1'b1, 4'd9, 16'h1234, 1'b0, 4'd0);
    rd("r9_next", 4'd1, 4'd9);
    step("iss_r9_again", 1'b1, 1'b0, 4'd9, 4'd9, 1'b0, 4'd0, 16'h0, 1'b1, 4'd9);
    step("bypass_reissue", 1'b1, 1'b0, 4'd9, 4'd9, 1'b1, 4'd9, 16'h4321, 1'b1, 4'd9);
    rd("r9_reissued", 4'd9, 4'd0);

    // Mid-operation reset discards pending state; a same-cycle writeback is dropped
    step("iss_r4", 1'b1, 1'b0, 4'd4, 4'd0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd4);
    rd("r4_busy", 4'd4, 4'd4);
    step("mid_rst", 1'b1, 1'b1, 4'd4, 4'd0, 1'b1, 4'd4, 16'hDEAD, 1'b0, 4'd0);
    rd("r4_cleared", 4'd4, 4'd4);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step("random", 1'b1, ($urandom_range(0, 99) == 0),
           4'($urandom), 4'($urandom),
           1'($urandom), 4'($urandom), 16'($urandom),
           1'($urandom), 4'($urandom));
    end

    repeat (3) @(posedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
